// File: rtl/regb_fifo_wr_arbiter.sv
// Write-port arbiter for a register-based FIFO: round-robin grant with burst lock.
// Optional beat limit per grant when ARB_BURST_LIMIT_EN is defined (MAX_BURST beats).
//
// Ports:
//   clk, res_n      clock, asynchronous active-low reset
//   req, last       per-requester beat valid / last-beat-of-burst flag
//   wdata_in        requester data, requester i in [i*WIDTH +: WIDTH]
//   ack, grant      per-requester beat accepted / one-hot current owner
//   busy            arbiter is inside a burst
//   fifo_full       FIFO full flag
//   fifo_wdata      data to the FIFO
//   fifo_shift_in   write strobe to the FIFO
module regb_fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*WIDTH-1:0] wdata_in,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    input  logic                  fifo_full,
    output logic [WIDTH-1:0]      fifo_wdata,
    output logic                  fifo_shift_in
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("regb_fifo_wr_arbiter: NREQ must be 2..16");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("regb_fifo_wr_arbiter: MAX_BURST must be 1..255");
    end

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   owner_inc;
    logic            found;
    logic            beat;
    logic            limit_hit;
    logic            rel;

    // First requesting index at or after rr_q, wrapping modulo NREQ.
    always_comb begin : p_search
        int          idx;
        logic [IW-1:0] ix;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        ix    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            ix = IW'(idx);
            if (!found && req[ix]) begin
                found = 1'b1;
                pick  = ix;
            end
        end
    end

    assign owner_inc = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    assign busy  = (state_q == BURST);
    assign grant = busy ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign beat  = busy & req[owner_q] & ~fifo_full;
    assign ack   = grant & {NREQ{beat}};

    assign fifo_shift_in = beat;
    assign fifo_wdata    = busy ? wdata_in[owner_q*WIDTH +: WIDTH] : '0;

`ifdef ARB_BURST_LIMIT_EN
    // The beat being accepted now is beat number cnt_q+1 of this grant.
    assign limit_hit = ({1'b0, cnt_q} + 9'd1) == 9'(MAX_BURST);
`else
    assign limit_hit = 1'b0;
`endif

    assign rel = beat & (last[owner_q] | limit_hit);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (beat && cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // Releasing owner moves to lowest priority.
                if (rel) begin
                    state_d = IDLE;
                    rr_d    = owner_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regb_fifo_wr_arbiter.sv
// Directed bench for regb_fifo_wr_arbiter.
// Includes a small depth-5 FIFO model for the end-to-end fill/drain sequence.
module tb_regb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        res_n;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] wdata_in;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  fifo_wdata;
    logic        fifo_shift_in;

    int checks = 0;
    int fails  = 0;

    logic [7:0] fq[$];
    int         ord[$];
    logic [3:0] seq[3];
    int         nacks;
    logic [7:0] exp6[5] = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h11};
    int         ordexp[5] = '{0, 1, 2, 0, 1};

    always #5 clk = ~clk;

    regb_fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .res_n         (res_n),
        .req           (req),
        .last          (last),
        .wdata_in      (wdata_in),
        .ack           (ack),
        .grant         (grant),
        .busy          (busy),
        .fifo_full     (fifo_full),
        .fifo_wdata    (fifo_wdata),
        .fifo_shift_in (fifo_shift_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_d(input int i, input logic [7:0] v);
        wdata_in[i*8 +: 8] = v;
    endtask

    initial begin
        res_n     = 1'b0;
        req       = '0;
        last      = '0;
        wdata_in  = 32'hD3C2B1A0;
        fifo_full = 1'b0;
        #2;
        chk("rst_grant", 32'(grant), 'h0);
        chk("rst_busy", 32'(busy), 'h0);
        chk("rst_ack", 32'(ack), 'h0);
        chk("rst_shift", 32'(fifo_shift_in), 'h0);
        chk("rst_wdata", 32'(fifo_wdata), 'h0);
        tick();
        res_n = 1'b1;

        // Burst lock: req0 sends 3 beats while req2 waits.
        req  = 4'b0101;
        last = 4'b0000;
        settle();
        chk("t3_idle_busy", 32'(busy), 'h0);
        chk("t3_idle_ack", 32'(ack), 'h0);
        tick();
        for (int b = 0; b < 3; b++) begin
            last = (b == 2) ? 4'b0001 : 4'b0000;
            set_d(0, 8'(8'h30 + b));
            settle();
            chk("t3_grant", 32'(grant), 'h1);
            chk("t3_ack", 32'(ack), 'h1);
            chk("t3_wdata", 32'(fifo_wdata), 32'h30 + b);
            tick();
        end
        last = 4'b0000;
        settle();
        chk("t3_rel_busy", 32'(busy), 'h0);
        tick();
        chk("t3_next_grant", 32'(grant), 'h4);
        req  = 4'b0100;
        last = 4'b0100;
        settle();
        chk("t3_next_ack", 32'(ack), 'h4);
        tick();
        req  = '0;
        last = '0;

        // Reset in the middle of a burst; search restarts at 0.
        req = 4'b0100;
        set_d(2, 8'h77);
        settle();
        chk("t1_idle", 32'(busy), 'h0);
        tick();
        chk("t1_beat_ack", 32'(ack), 'h4);
        chk("t1_beat_busy", 32'(busy), 'h1);
        res_n = 1'b0;
        settle();
        chk("t1_rst_grant", 32'(grant), 'h0);
        chk("t1_rst_busy", 32'(busy), 'h0);
        chk("t1_rst_ack", 32'(ack), 'h0);
        chk("t1_rst_shift", 32'(fifo_shift_in), 'h0);
        chk("t1_rst_wdata", 32'(fifo_wdata), 'h0);
        res_n = 1'b1;
        req   = 4'b1001;
        last  = 4'b1001;
        tick();
        chk("t1_from0_grant", 32'(grant), 'h1);
        chk("t1_from0_ack", 32'(ack), 'h1);
        tick();
        req  = '0;
        last = '0;

        // Round robin with all requesting, pointer starts at 1.
        req      = 4'b1111;
        last     = 4'b1111;
        wdata_in = 32'hA3A2A1A0;
        settle();
        for (int k = 0; k < 5; k++) begin
            int g;
            g = (1 + k) % 4;
            chk("t2_idle", 32'(busy), 'h0);
            tick();
            chk("t2_grant", 32'(grant), 32'(1) << g);
            chk("t2_ack", 32'(ack), 32'(1) << g);
            chk("t2_wdata", 32'(fifo_wdata), 32'hA0 + g);
            tick();
        end
        req  = '0;
        last = '0;

        // Full backpressure on req2 (pointer now 2).
        req       = 4'b0100;
        fifo_full = 1'b1;
        set_d(2, 8'h5A);
        settle();
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t4_shift", 32'(fifo_shift_in), 'h0);
            chk("t4_ack", 32'(ack), 'h0);
            chk("t4_wdata", 32'(fifo_wdata), 'h5A);
            chk("t4_grant", 32'(grant), 'h4);
            tick();
        end
        fifo_full = 1'b0;
        settle();
        chk("t4_beat_shift", 32'(fifo_shift_in), 'h1);
        chk("t4_beat_ack", 32'(ack), 'h4);
        chk("t4_beat_wdata", 32'(fifo_wdata), 'h5A);
        tick();
        set_d(2, 8'h5B);
        last = 4'b0100;
        settle();
        chk("t4_beat2_ack", 32'(ack), 'h4);
        chk("t4_beat2_wdata", 32'(fifo_wdata), 'h5B);
        tick();
        req  = '0;
        last = '0;
        settle();
        chk("t4_rel", 32'(busy), 'h0);

        // Pointer is 3: one beat from req3 moves it to 0.
        req  = 4'b1000;
        last = 4'b1000;
        set_d(3, 8'h33);
        tick();
        chk("t5_pre_ack", 32'(ack), 'h8);
        tick();

        // req1 bursts 6 beats while req3 waits.
        req  = 4'b1010;
        last = 4'b1000;
        settle();
        chk("t5_idle", 32'(busy), 'h0);
        tick();
        for (int b = 0; b < 6; b++) begin
`ifdef ARB_BURST_LIMIT_EN
            if (b == 4) begin
                last = 4'b1000;
                settle();
                chk("t5_lim_idle", 32'(busy), 'h0);
                tick();
                chk("t5_lim_g3", 32'(grant), 'h8);
                chk("t5_lim_ack3", 32'(ack), 'h8);
                tick();
                chk("t5_lim_idle2", 32'(busy), 'h0);
                tick();
            end
`endif
            set_d(1, 8'(8'h10 + b));
            last = (b == 5) ? 4'b1010 : 4'b1000;
            settle();
            chk("t5_grant", 32'(grant), 'h2);
            chk("t5_ack", 32'(ack), 'h2);
            chk("t5_wdata", 32'(fifo_wdata), 32'h10 + b);
            tick();
        end
`ifndef ARB_BURST_LIMIT_EN
        chk("t5_idle_end", 32'(busy), 'h0);
        tick();
        chk("t5_g3", 32'(grant), 'h8);
        chk("t5_ack3", 32'(ack), 'h8);
        tick();
`endif
        req  = '0;
        last = '0;

        // End-to-end fill of a depth-5 FIFO from three requesters.
        res_n = 1'b0;
        settle();
        res_n = 1'b1;
        req   = 4'b0111;
        last  = 4'b0111;
        nacks = 0;
        for (int i = 0; i < 3; i++) seq[i] = '0;
        for (int c = 0; c < 20; c++) begin
            fifo_full = (fq.size() >= 5);
            for (int i = 0; i < 3; i++) set_d(i, {4'(i), seq[i]});
            settle();
            if (fifo_shift_in) fq.push_back(fifo_wdata);
            for (int i = 0; i < 3; i++) begin
                if (ack[i]) begin
                    seq[i] = seq[i] + 4'd1;
                    nacks++;
                    ord.push_back(i);
                end
            end
            tick();
        end
        settle();
        chk("t6_acks", 32'(nacks), 'h5);
        chk("t6_full_shift", 32'(fifo_shift_in), 'h0);
        chk("t6_full_ack", 32'(ack), 'h0);
        chk("t6_fifo_level", 32'(fq.size()), 'h5);
        for (int i = 0; i < 5; i++) begin
            int o;
            logic [7:0] d;
            o = (ord.size() > 0) ? ord.pop_front() : -1;
            d = (fq.size() > 0) ? fq.pop_front() : 8'hXX;
            chk("t6_order", 32'(o), 32'(ordexp[i]));
            chk("t6_drain", 32'(d), 32'(exp6[i]));
        end
        fifo_full = 1'b0;
        settle();
        chk("t6_resume_ack", 32'(ack), 'h4);
        chk("t6_resume_wdata", 32'(fifo_wdata), 'h21);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
